// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Ports: clk, rst_n (async low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/sum/cout result handshake.
//        Optional ovf (signed overflow) when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..32");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic [CW-1:0]    cnt;
  logic             c;

  // Two half-adder stages: (a,b) then (partial, carry).
  logic h1, g1, s, g2, c_nx;
  assign h1   = a_sr[0] ^ b_sr[0];
  assign g1   = a_sr[0] & b_sr[0];
  assign s    = h1 ^ c;
  assign g2   = h1 & c;
  assign c_nx = g1 | g2;

  logic accept, last;
  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      sum_r <= '0;
      cnt   <= '0;
      c     <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      sum_r <= '0;
      cnt   <= '0;
      c     <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum_r <= {s, sum_r[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      c     <= c_nx;
    end
  end

  assign sum  = sum_r;
  assign cout = c;

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit, c is the carry into the MSB and c_nx the carry out.
  logic ovf_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_r <= 1'b0;
    else if (accept) ovf_r <= 1'b0;
    else if (last)   ovf_r <= c ^ c_nx;
  end
  assign ovf = ovf_r;
`else
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder.
// Accept watcher pushes model results; a monitor pops on each hand-off.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   b2b = 0;
  bit   rnd = 0;
  int   last_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int acc);
    exp_t m;
    int   u, sr;
    u  = int'(x) + int'(y);
    sr = int'($signed(x)) + int'($signed(y));
    m.s   = W'(u % (1 << W));
    m.c   = (u >= (1 << W));
    m.o   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    m.acc = acc;
    return m;
  endfunction

  // Accept watcher
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(a, b, cyc + 1));
      if (b2b && last_acc >= 0)
        chk("accept_spacing", cyc + 1 - last_acc, W + 2);
      last_acc = cyc + 1;
    end
  end

  // Monitor
  bit           pv = 0;
  bit           handed = 0;
  logic [W-1:0] psum;
  logic         pcout;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      handed = 0;
    end else begin
      if (handed) begin
        chk("in_ready_after_handoff", in_ready, 1);
        handed = 0;
      end
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 0);
        if (!pv) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else chk("latency", cyc - q[0].acc, W);
        end else begin
          chk("sum_stable", sum, psum);
          chk("cout_stable", cout, pcout);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("result_without_accept", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", ovf, e.o);
`endif
          end
          handed = 1;
        end
      end
      pv    = out_valid;
      psum  = sum;
      pcout = cout;
    end
  end

  // Random backpressure during the random phase
  always @(posedge clk) begin
    if (rnd) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h00, 8'h00); wait_idle();
    send(8'h0F, 8'h01); wait_idle();
    send(8'hFF, 8'h01); wait_idle();
    send(8'hFF, 8'hFF); wait_idle();

    // Backpressure with an ignored second request
    out_ready = 1'b0;
    send(8'h35, 8'h4A);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-SHIFT
    send(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h01, 8'h02); wait_idle();

    // Back-to-back with in_valid held high
    b2b = 1;
    last_acc = -1;
    in_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) chk("b2b_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    b2b = 0;
    wait_idle();

    // Signed overflow corners
    send(8'h7F, 8'h01); wait_idle();
    send(8'h80, 8'h80); wait_idle();
    send(8'h10, 8'h20); wait_idle();

    // Random operands with random backpressure
    rnd = 1;
    for (int t = 0; t < 20; t++) begin
      send(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    @(posedge clk);
    rnd = 0;
    #2;
    out_ready = 1'b1;
    wait_idle();

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
